swc_packet_mem_write_scheduler: RTL and testbench
=================================================

Name: swc_packet_mem_write_scheduler

Overview:
- Time-division scheduler sharing the single packet-memory write port among NUM_PORTS write pumps.
- Runs a free-running slot counter and issues each pump's one-cycle sync pulse the cycle before that pump's slot.
- In the slot cycle it forwards the owning pump's write to memory with one cycle of latency.
- Drops and flags writes made outside the pump's slot; it sits between the per-port write pumps and the packet memory.

Parameters:
- NUM_PORTS, 11, number of write pumps (slots per round); legal 1..32.
- DATA_WIDTH, 320, memory word width (pump input width 20 x multiply 16).
- ADDR_WIDTH, 14, memory word address width.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  asynchronous active-high reset.
- en_i  input  NUM_PORTS  per-port enable mask; sampled every cycle.
- sync_o  output  NUM_PORTS  one-hot sync to pumps; bit k high the cycle before slot k.
- we_i  input  NUM_PORTS  per-pump write request.
- addr_i  input  NUM_PORTS*ADDR_WIDTH  packed per-pump address; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- data_i  input  NUM_PORTS*DATA_WIDTH  packed per-pump data; same packing rule.
- mem_we_o  output  1  memory write strobe.
- mem_addr_o  output  ADDR_WIDTH  memory address.
- mem_data_o  output  DATA_WIDTH  memory data.
- slot_o  output  clog2(NUM_PORTS), min 1  current slot number (debug).
- err_o  output  NUM_PORTS  sticky out-of-slot write flag per port.
- err_clr_i  input  NUM_PORTS  per-port error clear.
- drop_cnt_o  output  16  saturating count of dropped writes.

Behaviour:
- Reset (async, immediate): slot_q=0, sync_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, err_o=0, drop_cnt_o=0. Any in-flight write is discarded.
- Slot counter: slot_q <= (slot_q==NUM_PORTS-1) ? 0 : slot_q+1 every cycle. slot_o = slot_q.
- Sync: registered. sync_o <= onehot((slot_q+2) mod NUM_PORTS) & en_i. Invariant: sync_o[k]=1 in cycle t implies slot_q==k in cycle t+1. At most one bit set.
- First cycle after reset release: sync_o=0, so the slot-0 and slot-1 owners receive no sync in that round. This is intended.
- NUM_PORTS=1: slot_q is constant 0; sync_o = en_i[0] from the first edge on, i.e. continuous.
- Accept condition: we_i[k] & (slot_q==k) & en_i[k].
- Accepted write is registered next edge: mem_we_o=1 and mem_addr_o/mem_data_o = port k's fields. Latency is exactly 1 cycle.
- Otherwise mem_we_o=0 and mem_addr_o/mem_data_o hold their last values.
- Drop condition: we_i[j] with slot_q!=j, or with en_i[j]=0. The write is discarded; err_o[j] <= 1 next edge.
- Error flags: err_o[j] <= (err_o[j] & ~err_clr_i[j]) | drop[j]. A simultaneous set and clear leaves the flag set.
- drop_cnt_o <= min(drop_cnt_o + popcount(drop), 16'hFFFF). Multiple drops in one cycle add their popcount; the counter never wraps.
- en_i deasserted mid-round: a sync already issued stands. A write in that slot with en_i[k]=0 counts as a drop.
- No backpressure exists; the memory accepts one write per cycle unconditionally.

Test Plan:
- Reset release, all en_i=1, no we: sync_o[2] first asserts in cycle 1 (cycle 0 = first cycle after release). It then rotates one-hot with period 11; each slot_o==k is preceded by sync_o[k]. mem_we_o stays 0.
- Port 3 asserts we_i[3], addr=0x0123, data=pattern in the cycle after sync_o[3] -> next cycle mem_we_o=1, mem_addr_o=0x0123, mem_data_o=pattern. No errors.
- All 11 ports write only in their own slots for 3 rounds -> 33 memory writes in slot order. err_o=0, drop_cnt_o=0.
- Ports 1 and 5 assert we_i while slot_q=0 -> no mem write. err_o[1] and err_o[5] set; drop_cnt_o +2. err_clr_i[5] pulsed alone clears only bit 5. Clear pulsed in the same cycle as a new drop leaves the flag set.
- en_i[4]=0 -> sync_o[4] never asserts. A write from port 4 in its slot is dropped and flagged.
- rst_i asserted in the cycle a write is registered -> mem_we_o falls immediately, with no memory write that cycle. After release the slot sequence restarts at 0. drop_cnt_o forced to 0xFFFE with 2 drops in one cycle -> saturates at 0xFFFF.

Source files
------------

// File: rtl/swc_packet_mem_write_scheduler.sv
// Time-division write-port scheduler: rotates ownership of the packet-memory write
// port among the write pumps, pre-announcing each slot with a one-cycle sync pulse.
module swc_packet_mem_write_scheduler #(
    parameter int NUM_PORTS  = 11,
    parameter int DATA_WIDTH = 320,
    parameter int ADDR_WIDTH = 14,
    localparam int SLOT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_PORTS-1:0]             en_i,
    output logic [NUM_PORTS-1:0]             sync_o,
    input  logic [NUM_PORTS-1:0]             we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data_i,
    output logic                             mem_we_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_data_o,
    output logic [SLOT_W-1:0]                slot_o,
    output logic [NUM_PORTS-1:0]             err_o,
    input  logic [NUM_PORTS-1:0]             err_clr_i,
    output logic [15:0]                      drop_cnt_o
);

    logic [SLOT_W-1:0]     r_slot;
    logic [NUM_PORTS-1:0]  r_sync;
    logic [NUM_PORTS-1:0]  r_err;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic [15:0]           r_drop_cnt;

    logic [SLOT_W+1:0]     w_slot_p2;
    logic [NUM_PORTS-1:0]  w_sync_next;
    logic [NUM_PORTS-1:0]  w_acc;
    logic [NUM_PORTS-1:0]  w_drop;
    logic [ADDR_WIDTH-1:0] w_addr_sel;
    logic [DATA_WIDTH-1:0] w_data_sel;
    logic [5:0]            w_drop_pop;
    logic [16:0]           w_cnt_sum;

    // Sync targets the slot two ahead; slot+2 never exceeds 3*NUM_PORTS, so matching
    // against k, k+N and k+2N is a full modulo without a divider.
    assign w_slot_p2 = {2'b00, r_slot} + (SLOT_W+2)'(2);

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            localparam logic [SLOT_W+1:0] K0 = (SLOT_W+2)'(gi);
            localparam logic [SLOT_W+1:0] K1 = (SLOT_W+2)'(gi + NUM_PORTS);
            localparam logic [SLOT_W+1:0] K2 = (SLOT_W+2)'(gi + 2*NUM_PORTS);
            assign w_sync_next[gi] = en_i[gi] &
                ((w_slot_p2 == K0) | (w_slot_p2 == K1) | (w_slot_p2 == K2));
            assign w_acc[gi]  = we_i[gi] & en_i[gi] & (r_slot == SLOT_W'(gi));
            assign w_drop[gi] = we_i[gi] & ~w_acc[gi];
        end
    endgenerate

    always_comb begin
        w_addr_sel = '0;
        w_data_sel = '0;
        w_drop_pop = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_acc[k]) begin
                w_addr_sel = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_data_sel = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            w_drop_pop = w_drop_pop + 6'(w_drop[k]);
        end
        w_cnt_sum = {1'b0, r_drop_cnt} + 17'(w_drop_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_slot     <= '0;
            r_sync     <= '0;
            r_err      <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_slot   <= (r_slot == SLOT_W'(NUM_PORTS-1)) ? '0 : r_slot + 1'b1;
            r_sync   <= w_sync_next;
            r_mem_we <= |w_acc;
            if (|w_acc) begin
                r_mem_addr <= w_addr_sel;
                r_mem_data <= w_data_sel;
            end
            // Set wins over clear so a drop in the clearing cycle is never lost.
            r_err      <= (r_err & ~err_clr_i) | w_drop;
            r_drop_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end

    assign slot_o     = r_slot;
    assign sync_o     = r_sync;
    assign err_o      = r_err;
    assign mem_we_o   = r_mem_we;
    assign mem_addr_o = r_mem_addr;
    assign mem_data_o = r_mem_data;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_swc_packet_mem_write_scheduler.sv
// Randomised self-checking bench for the packet-memory write scheduler, checked
// against a cycle-indexed reference model (slot = cycles since reset mod N).
module tb_swc_packet_mem_write_scheduler;

    localparam int N  = 11;
    localparam int AW = 14;
    localparam int DW = 320;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    en, we, clr;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N-1:0]    sync_o, err_o;
    logic            mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_data_o;
    logic [SW-1:0]   slot_o;
    logic [15:0]     drop_cnt_o;

    swc_packet_mem_write_scheduler #(.NUM_PORTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .sync_o(sync_o), .we_i(we),
        .addr_i(addr), .data_i(data), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .slot_o(slot_o), .err_o(err_o),
        .err_clr_i(clr), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    int            m_t;
    logic [N-1:0]  m_sync, m_err;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_cnt;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [DW-1:0] rdata();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_init();
        m_t = 0; m_sync = '0; m_err = '0; m_we = 1'b0;
        m_addr = '0; m_data = '0; m_cnt = 0;
    endtask

    // Advance one clock with the currently driven inputs and update the model.
    task automatic step();
        int owner, ndrop, tgt;
        logic [N-1:0] en_s, we_s, clr_s, new_err;
        logic [N*AW-1:0] addr_s;
        logic [N*DW-1:0] data_s;
        owner = m_t % N;
        en_s = en; we_s = we; clr_s = clr; addr_s = addr; data_s = data;
        @(posedge clk);
        #1;
        m_we = 1'b0;
        ndrop = 0;
        new_err = m_err & ~clr_s;
        for (int k = 0; k < N; k++) begin
            if (we_s[k]) begin
                if (k == owner && en_s[k]) begin
                    m_we = 1'b1;
                    m_addr = addr_s[k*AW +: AW];
                    m_data = data_s[k*DW +: DW];
                end else begin
                    ndrop++;
                    new_err[k] = 1'b1;
                end
            end
        end
        m_err = new_err;
        m_cnt = (m_cnt + ndrop > 65535) ? 65535 : m_cnt + ndrop;
        // The pump owning the slot two cycles ahead is warned if enabled now.
        tgt = (m_t + 2) % N;
        m_sync = '0;
        m_sync[tgt] = en_s[tgt];
        m_t++;
    endtask

    task automatic do_reset();
        rst = 1'b1; we = '0; clr = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
    endtask

    task automatic align(input int k);
        we = '0; clr = '0;
        while (m_t % N != k) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '1; we = '0; clr = '0; addr = '0; data = '0;
        #1;
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we_async: got %b expected 0", mem_we_o); end
        do_reset();
        checks++; if (slot_o !== 4'd0) begin errors++; $display("FAIL reset_slot: got %0d expected 0", slot_o); end
        checks++; if (sync_o !== '0) begin errors++; $display("FAIL reset_sync: got %h expected 0", sync_o); end
        checks++; if (mem_we_o !== 1'b0 || mem_addr_o !== '0 || mem_data_o !== '0) begin errors++; $display("FAIL reset_mem: got we=%b addr=%h expected we=0 addr=0", mem_we_o, mem_addr_o); end
        checks++; if (err_o !== '0 || drop_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_err: got err=%h cnt=%0d expected 0 0", err_o, drop_cnt_o); end
        $display("test_reset done");
    endtask

    task automatic test_rotation();
        logic [N-1:0] prev;
        step();
        checks++; if (sync_o !== 11'b00000000100) begin errors++; $display("FAIL first_sync: got %b expected 00000000100", sync_o); end
        for (int i = 0; i < 3*N; i++) begin
            prev = sync_o;
            step();
            checks++; if (slot_o !== SW'(m_t % N)) begin errors++; $display("FAIL rot_slot: got %0d expected %0d", slot_o, m_t % N); end
            checks++; if (sync_o !== m_sync) begin errors++; $display("FAIL rot_sync: got %b expected %b", sync_o, m_sync); end
            for (int k = 0; k < N; k++)
                if (prev[k]) begin
                    checks++; if (slot_o !== SW'(k)) begin errors++; $display("FAIL sync_precedes_slot: got slot %0d expected %0d", slot_o, k); end
                end
            checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rot_mem_we: got %b expected 0", mem_we_o); end
        end
        $display("test_rotation done");
    endtask

    task automatic test_single_write();
        logic [DW-1:0] pat;
        align(3);
        pat = rdata();
        we = '0; we[3] = 1'b1;
        addr[3*AW +: AW] = 14'h0123;
        data[3*DW +: DW] = pat;
        step();
        we = '0;
        $display("write port 3 addr=%h", mem_addr_o);
        checks++; if (mem_we_o !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", mem_we_o); end
        checks++; if (mem_addr_o !== 14'h0123) begin errors++; $display("FAIL single_addr: got %h expected 0123", mem_addr_o); end
        checks++; if (mem_data_o !== pat) begin errors++; $display("FAIL single_data: got %h expected %h", mem_data_o, pat); end
        checks++; if (err_o !== '0) begin errors++; $display("FAIL single_err: got %h expected 0", err_o); end
        step();
        checks++; if (mem_we_o !== 1'b0 || mem_addr_o !== 14'h0123) begin errors++; $display("FAIL single_hold: got we=%b addr=%h expected we=0 addr=0123", mem_we_o, mem_addr_o); end
    endtask

    task automatic test_own_slots();
        int writes, owner;
        writes = 0;
        align(0);
        for (int i = 0; i < 3*N; i++) begin
            owner = m_t % N;
            we = '0; we[owner] = 1'b1;
            addr[owner*AW +: AW] = AW'($urandom);
            data[owner*DW +: DW] = rdata();
            step();
            if (mem_we_o === 1'b1) writes++;
            $display("write slot %0d addr=%h", owner, mem_addr_o);
            checks++; if (mem_we_o !== m_we || mem_addr_o !== m_addr || mem_data_o !== m_data) begin errors++; $display("FAIL own_write: got we=%b addr=%h expected we=%b addr=%h", mem_we_o, mem_addr_o, m_we, m_addr); end
        end
        we = '0;
        checks++; if (writes != 3*N) begin errors++; $display("FAIL own_count: got %0d expected %0d", writes, 3*N); end
        checks++; if (err_o !== '0 || drop_cnt_o !== 16'd0) begin errors++; $display("FAIL own_err: got err=%h cnt=%0d expected 0 0", err_o, drop_cnt_o); end
    endtask

    task automatic test_drops();
        align(0);
        we = '0; we[1] = 1'b1; we[5] = 1'b1;
        step();
        we = '0;
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL drop_we: got %b expected 0", mem_we_o); end
        checks++; if (err_o !== 11'b00000100010) begin errors++; $display("FAIL drop_err: got %b expected 00000100010", err_o); end
        checks++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL drop_cnt: got %0d expected 2", drop_cnt_o); end
        clr = '0; clr[5] = 1'b1;
        step();
        checks++; if (err_o !== 11'b00000000010 || err_o !== m_err) begin errors++; $display("FAIL clr_one: got %b expected 00000000010", err_o); end
        align(0);
        clr = '0; clr[5] = 1'b1; we[5] = 1'b1;
        step();
        we = '0; clr = '0;
        checks++; if (err_o[5] !== 1'b1) begin errors++; $display("FAIL set_over_clr: got %b expected 1", err_o[5]); end
        checks++; if (drop_cnt_o !== 16'(m_cnt)) begin errors++; $display("FAIL drop_cnt2: got %0d expected %0d", drop_cnt_o, m_cnt); end
        clr = '1;
        step();
        clr = '0;
        checks++; if (err_o !== '0) begin errors++; $display("FAIL clr_all: got %b expected 0", err_o); end
    endtask

    task automatic test_enable();
        en = '1; en[4] = 1'b0;
        step();
        for (int i = 0; i < 2*N; i++) begin
            step();
            checks++; if (sync_o[4] !== 1'b0 || sync_o !== m_sync) begin errors++; $display("FAIL en_sync: got %b expected %b", sync_o, m_sync); end
        end
        align(4);
        we = '0; we[4] = 1'b1;
        step();
        we = '0;
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL en_drop_we: got %b expected 0", mem_we_o); end
        checks++; if (err_o[4] !== 1'b1 || drop_cnt_o !== 16'(m_cnt)) begin errors++; $display("FAIL en_drop_err: got err4=%b cnt=%0d expected 1 %0d", err_o[4], drop_cnt_o, m_cnt); end
        en = '1; clr = '1;
        step();
        clr = '0;
    endtask

    task automatic test_random();
        int owner;
        for (int i = 0; i < 300; i++) begin
            owner = m_t % N;
            en  = N'($urandom | $urandom | $urandom);
            we  = N'($urandom & $urandom & $urandom);
            we[owner] = $urandom_range(0, 1) != 0;
            clr = N'($urandom & $urandom);
            for (int k = 0; k < N; k++) begin
                addr[k*AW +: AW] = AW'($urandom);
                data[k*DW +: DW] = rdata();
            end
            step();
            checks++; if (slot_o !== SW'(m_t % N) || sync_o !== m_sync) begin errors++; $display("FAIL rnd_sched: got slot=%0d sync=%b expected slot=%0d sync=%b", slot_o, sync_o, m_t % N, m_sync); end
            checks++; if (mem_we_o !== m_we || mem_addr_o !== m_addr || mem_data_o !== m_data) begin errors++; $display("FAIL rnd_mem: got we=%b addr=%h expected we=%b addr=%h", mem_we_o, mem_addr_o, m_we, m_addr); end
            checks++; if (err_o !== m_err || drop_cnt_o !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_err: got err=%b cnt=%0d expected err=%b cnt=%0d", err_o, drop_cnt_o, m_err, m_cnt); end
        end
        en = '1; we = '0; clr = '0;
    endtask

    task automatic test_reset_midwrite();
        int owner;
        owner = m_t % N;
        we = '0; we[owner] = 1'b1;
        addr[owner*AW +: AW] = 14'h2AAA;
        step();
        we = '0;
        checks++; if (mem_we_o !== 1'b1) begin errors++; $display("FAIL pre_rst_we: got %b expected 1", mem_we_o); end
        rst = 1'b1;
        #1;
        checks++; if (mem_we_o !== 1'b0 || mem_addr_o !== '0 || slot_o !== '0) begin errors++; $display("FAIL async_rst: got we=%b addr=%h slot=%0d expected 0 0 0", mem_we_o, mem_addr_o, slot_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
        step();
        checks++; if (slot_o !== 4'd1 || mem_we_o !== 1'b0) begin errors++; $display("FAIL restart_slot: got slot=%0d we=%b expected 1 0", slot_o, mem_we_o); end
    endtask

    task automatic test_saturation();
        en = '0; we = '1;
        while (65534 - m_cnt >= N) step();
        we = N'((1 << (65534 - m_cnt)) - 1);
        step();
        checks++; if (drop_cnt_o !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected fffe", drop_cnt_o); end
        we = 11'b00000000011;
        step();
        checks++; if (drop_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h expected ffff", drop_cnt_o); end
        we = '1;
        step();
        checks++; if (drop_cnt_o !== 16'hFFFF || drop_cnt_o !== 16'(m_cnt)) begin errors++; $display("FAIL sat_hold: got %h expected ffff", drop_cnt_o); end
        we = '0; en = '1;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_write();
        test_own_slots();
        test_drops();
        test_enable();
        test_random();
        test_reset_midwrite();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
